// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Read-side initiator for the register file. A start pulse walks every
//   register selected by the mask, lowest index first. Each register is read
//   in one cycle and then presented as one {addr,data} beat on a valid/ready
//   stream. A read that coincides with a write to the same register is
//   retried, up to RETRY_MAX times. If the collision outlasts the retries, the
//   beat is sent with out_stale set.
// Ports
//   clock, reset_n          clock, synchronous active-low reset
//   start, abort, mask      dump request / cancel / register select
//   ra, read_data           register file read port
//   rf_reg_write, rf_wa,
//   rf_iszero_write         snooped register file write controls
//   out_valid/ready/addr/
//   data/stale/last         beat stream to the debug/trace sink
//   busy, done, aborted     status
module reg_dump_reader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int RETRY_MAX = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [(1<<ADDR_W)-1:0]  mask,
  output logic [ADDR_W-1:0]       ra,
  input  logic [DATA_W-1:0]       read_data,
  input  logic                    rf_reg_write,
  input  logic [ADDR_W-1:0]       rf_wa,
  input  logic                    rf_iszero_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_stale,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int RW    = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stale;
    logic              last;
  } beat_t;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [RW-1:0]     retry_q, retry_d;
  beat_t             beat_q, beat_d;
  logic              aborted_q, aborted_d;

  logic [DEPTH-1:0]  higher;
  logic              has_higher;
  logic              collide;

  // Priority pick: index of the lowest set bit.
  function automatic logic [ADDR_W-1:0] lowest(input logic [DEPTH-1:0] v);
    lowest = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (v[i]) lowest = ADDR_W'(i);
  endfunction

  // Mask bits strictly above the register being handled.
  always_comb begin
    higher = '0;
    for (int i = 0; i < DEPTH; i++)
      higher[i] = mask_q[i] && (ADDR_W'(i) > ra_q);
  end
  assign has_higher = |higher;

  // Reg 0 is never written through the normal port, and reg 3 is written by
  // the iszero path instead, so only those sources can tear a read.
  assign collide = (rf_reg_write && (rf_wa == ra_q) && (ra_q != '0) && (ra_q != ADDR_W'(3)))
                || (rf_iszero_write && (ra_q == ADDR_W'(3)));

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ra_d      = ra_q;
    retry_d   = retry_q;
    beat_d    = beat_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (|mask) begin
          mask_d  = mask;
          ra_d    = lowest(mask);
          state_d = READ;
        end else begin
          state_d = DONE;
        end
      end
      READ: if (collide && (retry_q < RW'(RETRY_MAX))) begin
        retry_d = RW'(retry_q + 1'b1);
      end else begin
        beat_d.addr  = ra_q;
        beat_d.data  = read_data;
        beat_d.stale = collide;
        beat_d.last  = !has_higher;
        retry_d      = '0;
        state_d      = SEND;
      end
      SEND: if (out_ready) begin
        if (has_higher) begin
          ra_d    = lowest(higher);
          state_d = READ;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a handshake in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      retry_d   = '0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      ra_q      <= '0;
      retry_q   <= '0;
      beat_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ra_q      <= ra_d;
      retry_q   <= retry_d;
      beat_q    <= beat_d;
      aborted_q <= aborted_d;
    end
  end

  assign ra        = ra_q;
  assign out_valid = (state_q == SEND);
  assign out_addr  = beat_q.addr;
  assign out_data  = beat_q.data;
  assign out_stale = beat_q.stale;
  assign out_last  = beat_q.last;
  assign busy      = (state_q != IDLE);
  // An abort arriving in DONE cancels the completion pulse.
  assign done      = (state_q == DONE) && !abort;
  assign aborted   = aborted_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;
  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic        s;
    logic        l;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] mask = '0;
  logic [3:0]  ra;
  logic [15:0] read_data;
  logic        rf_reg_write = 1'b0;
  logic [3:0]  rf_wa = '0;
  logic        rf_iszero_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_addr;
  logic [15:0] out_data;
  logic        out_stale, out_last, busy, done, aborted;

  logic [15:0] rf [16];
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, abort_cnt = 0, beat_cnt = 0;
  beat_t sb[$];
  beat_t cur_b, prev_b, exp_b;
  logic  prev_hold = 1'b0;

  assign read_data = rf[ra];

  always #5 clock = ~clock;

  reg_dump_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .mask(mask),
    .ra(ra), .read_data(read_data), .rf_reg_write(rf_reg_write), .rf_wa(rf_wa),
    .rf_iszero_write(rf_iszero_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_stale(out_stale), .out_last(out_last),
    .busy(busy), .done(done), .aborted(aborted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks that an
  // unaccepted beat stays frozen.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
    end else begin
      cur_b = {out_addr, out_data, out_stale, out_last};
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (out_valid && prev_hold) check("hold_stable", cur_b, prev_b);
      if (out_valid && out_ready && !abort) begin
        beat_cnt++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat_unexpected: got beat 0x%0h, expected none", cur_b);
        end else begin
          exp_b = sb.pop_front();
          check("beat", cur_b, exp_b);
        end
      end
      prev_hold = out_valid && !(out_ready && !abort);
      prev_b    = cur_b;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [15:0] m);
    start = 1'b1;
    mask  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100 && busy; k++) tick();
    check(name, busy, 0);
  endtask

  initial begin
    int d0, a0, b0;
    logic found;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // reset state
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_ra", ra, 0);
    check("rst_beat", {out_addr, out_data, out_stale, out_last}, 0);
    reset_n = 1'b1;
    tick();

    // 1: two-register dump, sink always ready
    rf[1] = 16'd1024; rf[2] = 16'd7;
    sb.push_back({4'd1, 16'd1024, 1'b0, 1'b0});
    sb.push_back({4'd2, 16'd7, 1'b0, 1'b1});
    d0 = done_cnt;
    go(16'h0006);
    check("t1_busy", busy, 1);
    check("t1_ra_first", ra, 1);
    repeat (3) tick();
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_busy_in_done", busy, 1);
    tick();
    check("t1_done_clear", done, 0);
    check("t1_idle", busy, 0);
    check("t1_ra_hold", ra, 2);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_done_cnt", done_cnt - d0, 1);

    // 2: back-pressure holds beat 0, then reg 15
    out_ready = 1'b0;
    rf[15] = 16'h1234;
    sb.push_back({4'd0, 16'h0000, 1'b0, 1'b0});
    sb.push_back({4'd15, 16'h1234, 1'b0, 1'b1});
    d0 = done_cnt;
    go(16'h8001);
    tick();
    for (int k = 0; k < 10; k++) begin
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_addr", out_addr, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t2_finish");
    check("t2_sb_empty", sb.size(), 0);
    check("t2_done_cnt", done_cnt - d0, 1);

    // 3: short collision on reg 5, retries then clean capture
    rf[5] = 16'h1111;
    sb.push_back({4'd5, 16'hA5A5, 1'b0, 1'b1});
    rf_reg_write = 1'b1; rf_wa = 4'd5;
    go(16'h0020);
    tick();
    check("t3_retry1", out_valid, 0);
    tick();
    rf_reg_write = 1'b0; rf[5] = 16'hA5A5;
    tick();
    check("t3_sent", out_valid, 1);
    wait_idle("t3_finish");

    // 3b: long collision, beat goes out stale after 3 retries
    rf[5] = 16'h1111;
    sb.push_back({4'd5, 16'h1111, 1'b1, 1'b1});
    rf_reg_write = 1'b1; rf_wa = 4'd5;
    go(16'h0020);
    for (int k = 0; k < 3; k++) begin
      check("t3b_reading", out_valid, 0);
      tick();
    end
    tick();
    check("t3b_sent", out_valid, 1);
    tick();
    rf_reg_write = 1'b0;
    wait_idle("t3b_finish");

    // 4: iszero write collides on reg 3; normal write to reg 3 does not
    rf[3] = 16'h3333;
    sb.push_back({4'd3, 16'h0001, 1'b0, 1'b1});
    rf_iszero_write = 1'b1;
    go(16'h0008);
    tick();
    check("t4_retry", out_valid, 0);
    rf_iszero_write = 1'b0; rf[3] = 16'h0001;
    rf_reg_write = 1'b1; rf_wa = 4'd3;
    tick();
    check("t4_wa3_no_collide", out_valid, 1);
    rf_reg_write = 1'b0;
    wait_idle("t4_finish");

    // 4b: write to reg 0 never collides
    sb.push_back({4'd0, 16'h0000, 1'b0, 1'b1});
    rf_reg_write = 1'b1; rf_wa = 4'd0;
    go(16'h0001);
    tick();
    check("t4b_no_retry", out_valid, 1);
    rf_reg_write = 1'b0;
    wait_idle("t4b_finish");

    // 5: full dump aborted while beat 4 is pending (ready high: abort wins)
    for (int i = 0; i < 16; i++) rf[i] = 16'(16'h1000 + i * 16'h0111);
    for (int i = 0; i < 4; i++) sb.push_back({4'(i), rf[i], 1'b0, 1'b0});
    d0 = done_cnt; a0 = abort_cnt;
    go(16'hFFFF);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (out_valid && out_addr == 4'd4) found = 1'b1;
      else tick();
    end
    check("t5_reach_beat4", found, 1);
    abort = 1'b1;
    tick();
    check("t5_valid_drop", out_valid, 0);
    check("t5_aborted", aborted, 1);
    check("t5_idle", busy, 0);
    check("t5_no_done", done, 0);
    abort = 1'b0;
    tick();
    check("t5_aborted_pulse", aborted, 0);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_done_cnt", done_cnt - d0, 0);
    check("t5_abort_cnt", abort_cnt - a0, 1);
    sb.push_back({4'd0, rf[0], 1'b0, 1'b0});
    sb.push_back({4'd1, rf[1], 1'b0, 1'b1});
    go(16'h0003);
    check("t5_restart_ra", ra, 0);
    wait_idle("t5_restart_finish");
    check("t5_restart_sb", sb.size(), 0);

    // 6: empty mask, then start while busy
    d0 = done_cnt; b0 = beat_cnt;
    go(16'h0000);
    check("t6_busy", busy, 1);
    check("t6_done", done, 1);
    tick();
    check("t6_done_clear", done, 0);
    check("t6_idle", busy, 0);
    check("t6_done_cnt", done_cnt - d0, 1);
    check("t6_no_beats", beat_cnt - b0, 0);

    d0 = done_cnt; b0 = beat_cnt;
    sb.push_back({4'd2, rf[2], 1'b0, 1'b1});
    go(16'h0004);
    start = 1'b1; mask = 16'h0010;
    tick();
    tick();
    start = 1'b0; mask = '0;
    wait_idle("t6b_finish");
    tick();
    check("t6b_beats", beat_cnt - b0, 1);
    check("t6b_done_cnt", done_cnt - d0, 1);
    check("t6b_sb_empty", sb.size(), 0);
    check("t6b_still_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
